// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch and data requesters, the arbiter,
// and the single-port word memory. The arbiter takes the slave view.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16
);
  // fetch port
  logic                 if_req;
  logic [ADDR_SIZE-1:0] if_addr;
  logic                 if_ack;
  logic                 if_rvalid;
  logic [WORD_SIZE-1:0] if_rdata;
  // load/store port
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_ack;
  logic                 d_rvalid;
  logic [WORD_SIZE-1:0] d_rdata;
  // memory side
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_w_data;
  logic [WORD_SIZE-1:0] mem_r_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           mem_r_en, mem_w_en, mem_addr, mem_w_data
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           mem_r_en, mem_w_en, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port word memory. Data wins ties,
// but a pending fetch that has lost MAX_DEFER times in a row is forced through.
// One access per cycle; read data is routed back to the port that issued it.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int MAX_DEFER = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEFER);

  typedef enum logic       {IDLE, ACCESS}        state_t;
  typedef enum logic [1:0] {FETCH, DREAD, DWRITE} owner_t;

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic [DW-1:0]        defer_q, defer_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 r_en_q, r_en_d;
  logic                 w_en_q, w_en_d;
  logic                 if_rvalid_q, d_rvalid_q;
  logic [WORD_SIZE-1:0] if_rdata_q, d_rdata_q;

  logic force_f, if_ack, d_ack;

  // Grant: data first unless the fetch has been deferred to the limit.
  always_comb begin
    force_f = bus.if_req && (defer_q == DMAX);
    d_ack   = bus.d_req && !force_f;
    if_ack  = bus.if_req && (!bus.d_req || force_f);
  end

  // Access state, owner, memory bus registers and deferral counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= FETCH;
      defer_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      defer_q <= defer_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      r_en_q  <= r_en_d;
      w_en_q  <= w_en_d;
    end
  end

  // Next state: launch the granted access, otherwise idle the memory bus.
  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    r_en_d  = 1'b0;
    w_en_d  = 1'b0;
    if (d_ack) begin
      state_d = ACCESS;
      owner_d = bus.d_we ? DWRITE : DREAD;
      addr_d  = bus.d_addr;
      r_en_d  = !bus.d_we;
      w_en_d  = bus.d_we;
      if (bus.d_we) wdata_d = bus.d_wdata;
    end else if (if_ack) begin
      state_d = ACCESS;
      owner_d = FETCH;
      addr_d  = bus.if_addr;
      r_en_d  = 1'b1;
    end
    // count consecutive losses of a waiting fetch; any fetch win or idle fetch clears
    if (!bus.if_req || if_ack)          defer_d = '0;
    else if (d_ack && defer_q != DMAX)  defer_d = defer_q + 1'b1;
    else                                defer_d = defer_q;
  end

  // Completion: capture read data for the owner of the access ending at this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= (state_q == ACCESS) && (owner_q == FETCH);
      d_rvalid_q  <= (state_q == ACCESS) && (owner_q == DREAD);
      if ((state_q == ACCESS) && (owner_q == FETCH)) if_rdata_q <= bus.mem_r_data;
      if ((state_q == ACCESS) && (owner_q == DREAD)) d_rdata_q  <= bus.mem_r_data;
    end
  end

  // Outputs: combinational acks, everything else straight from registers.
  always_comb begin
    bus.if_ack     = if_ack;
    bus.d_ack      = d_ack;
    bus.if_rvalid  = if_rvalid_q;
    bus.if_rdata   = if_rdata_q;
    bus.d_rvalid   = d_rvalid_q;
    bus.d_rdata    = d_rdata_q;
    bus.mem_r_en   = r_en_q;
    bus.mem_w_en   = w_en_q;
    bus.mem_addr   = addr_q;
    bus.mem_w_data = wdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  mem_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bus ();

  mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16), .MAX_DEFER(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // memory model: async read, write at rising edge
  logic [15:0] mem [0:65535];
  assign bus.mem_r_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_w_en) mem[bus.mem_addr] <= bus.mem_w_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat;      // 1 = fetch wins, cycle 0 in bit 8
    logic       g, prev_g;
    logic [15:0] fa [0:2];
    logic [15:0] fd [0:2];

    mem[16'h0010] = 16'hBEEF;
    mem[16'h0200] = 16'hF00D;
    mem[16'h0300] = 16'hDA7A;
    mem[16'hFFFE] = 16'h1111;
    mem[16'hFFFF] = 16'h2222;
    mem[16'h0000] = 16'h3333;
    fa[0] = 16'hFFFE; fa[1] = 16'hFFFF; fa[2] = 16'h0000;
    fd[0] = 16'h1111; fd[1] = 16'h2222; fd[2] = 16'h3333;

    // ---- reset with requests active
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hAAAA;
    tick(); tick(); tick();
    chk("rst_r_en", 32'(bus.mem_r_en), 0);
    chk("rst_w_en", 32'(bus.mem_w_en), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_w_data), 0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("rst_if_rdata", 32'(bus.if_rdata), 0);
    chk("rst_d_rdata", 32'(bus.d_rdata), 0);
    chk("rst_d_ack", 32'(bus.d_ack), 1);
    chk("rst_if_ack", 32'(bus.if_ack), 0);
    chk("rst_mem_kept", 32'(mem[16'h0100]), 0);

    // ---- single fetch right after release
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    reset = 1'b1;
    #1;
    chk("f1_if_ack", 32'(bus.if_ack), 1);
    chk("f1_d_ack", 32'(bus.d_ack), 0);
    tick();
    bus.if_req = 1'b0;
    chk("f1_r_en", 32'(bus.mem_r_en), 1);
    chk("f1_w_en", 32'(bus.mem_w_en), 0);
    chk("f1_addr", 32'(bus.mem_addr), 32'h0010);
    chk("f1_rvalid_early", 32'(bus.if_rvalid), 0);
    tick();
    chk("f1_rvalid", 32'(bus.if_rvalid), 1);
    chk("f1_rdata", 32'(bus.if_rdata), 32'hBEEF);
    chk("f1_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("f1_r_en_off", 32'(bus.mem_r_en), 0);
    tick();
    chk("f1_rvalid_pulse", 32'(bus.if_rvalid), 0);
    chk("f1_rdata_hold", 32'(bus.if_rdata), 32'hBEEF);

    // ---- write then read
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
    #1;
    chk("wr_d_ack", 32'(bus.d_ack), 1);
    tick();
    chk("wr_w_en", 32'(bus.mem_w_en), 1);
    chk("wr_r_en", 32'(bus.mem_r_en), 0);
    chk("wr_addr", 32'(bus.mem_addr), 32'h0100);
    chk("wr_wdata", 32'(bus.mem_w_data), 32'h1234);
    bus.d_we = 1'b0;
    tick();
    chk("rd_w_en_off", 32'(bus.mem_w_en), 0);
    chk("rd_r_en", 32'(bus.mem_r_en), 1);
    chk("wr_no_rvalid", 32'(bus.d_rvalid), 0);
    bus.d_req = 1'b0;
    tick();
    chk("rd_rvalid", 32'(bus.d_rvalid), 1);
    chk("rd_rdata", 32'(bus.d_rdata), 32'h1234);
    chk("rd_if_rvalid", 32'(bus.if_rvalid), 0);
    tick();
    chk("rd_rvalid_pulse", 32'(bus.d_rvalid), 0);

    // ---- contention, MAX_DEFER=2 -> D,D,F repeating
    pat = 9'b001001001;
    bus.if_req = 1'b1; bus.if_addr = 16'h0200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
    prev_g = 1'b0;
    for (int i = 0; i < 9; i++) begin
      g = pat[8-i];
      #1;
      chk($sformatf("ct%0d_if_ack", i), 32'(bus.if_ack), 32'(g));
      chk($sformatf("ct%0d_d_ack", i), 32'(bus.d_ack), 32'(!g));
      tick();
      chk($sformatf("ct%0d_r_en", i), 32'(bus.mem_r_en), 1);
      chk($sformatf("ct%0d_addr", i), 32'(bus.mem_addr), g ? 32'h0200 : 32'h0300);
      if (i > 0) begin
        chk($sformatf("ct%0d_if_rv", i), 32'(bus.if_rvalid), 32'(prev_g));
        chk($sformatf("ct%0d_d_rv", i), 32'(bus.d_rvalid), 32'(!prev_g));
        if (prev_g) chk($sformatf("ct%0d_if_rd", i), 32'(bus.if_rdata), 32'hF00D);
        else        chk($sformatf("ct%0d_d_rd", i), 32'(bus.d_rdata), 32'hDA7A);
      end
      prev_g = g;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    chk("ct_last_if_rv", 32'(bus.if_rvalid), 1);
    chk("ct_last_d_rv", 32'(bus.d_rvalid), 0);
    chk("ct_idle_r_en", 32'(bus.mem_r_en), 0);

    // ---- back-to-back fetches across address wrap
    bus.if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.if_addr = fa[i];
      #1;
      chk($sformatf("bb%0d_if_ack", i), 32'(bus.if_ack), 1);
      tick();
      chk($sformatf("bb%0d_r_en", i), 32'(bus.mem_r_en), 1);
      chk($sformatf("bb%0d_addr", i), 32'(bus.mem_addr), 32'(fa[i]));
      if (i > 0) begin
        chk($sformatf("bb%0d_rv", i), 32'(bus.if_rvalid), 1);
        chk($sformatf("bb%0d_rd", i), 32'(bus.if_rdata), 32'(fd[i-1]));
      end
    end
    bus.if_req = 1'b0;
    tick();
    chk("bb_last_rv", 32'(bus.if_rvalid), 1);
    chk("bb_last_rd", 32'(bus.if_rdata), 32'h3333);

    // ---- reset in the ACCESS cycle of a data read
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
    tick();
    bus.d_req = 1'b0;
    chk("mr_r_en", 32'(bus.mem_r_en), 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_r_en_drop", 32'(bus.mem_r_en), 0);
    chk("mr_addr_clr", 32'(bus.mem_addr), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mr_d_rv%0d", i), 32'(bus.d_rvalid), 0);
    end
    reset = 1'b1;
    tick();
    chk("mr_d_rv_after", 32'(bus.d_rvalid), 0);
    chk("mr_d_rdata", 32'(bus.d_rdata), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
